// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between multi-beat fetch line reads, MR word reads
// and MW word writes; one access in flight at a time, completion signalled by mem_ack.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int BEATS      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    f_req_i,
    input  logic [ADDR_W-1:0]       f_addr_i,
    output logic                    f_done_o,
    output logic [BEATS*DATA_W-1:0] f_line_o,
    input  logic                    mr_req_i,
    input  logic [ADDR_W-1:0]       mr_addr_i,
    output logic                    mr_done_o,
    output logic [DATA_W-1:0]       mr_data_o,
    input  logic                    mw_req_i,
    input  logic [ADDR_W-1:0]       mw_addr_i,
    input  logic [DATA_W-1:0]       mw_wdata_i,
    output logic                    mw_done_o,
    output logic                    mr_stall_o,
    output logic                    mw_stall_o,
    output logic                    mem_re_o,
    output logic                    mem_we_o,
    output logic [ADDR_W-1:0]       mem_addr_o,
    output logic [DATA_W-1:0]       mem_wdata_o,
    input  logic [DATA_W-1:0]       mem_rdata_i,
    input  logic                    mem_ack_i
);

    localparam int LINE_W     = BEATS * DATA_W;
    localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WB_W       = $clog2(DATA_W / 8);
    localparam int OFF_W      = BEAT_W + WB_W;
    localparam int STARVE_W   = $clog2(STARVE_MAX + 1);
    localparam logic [BEAT_W-1:0]   BEAT_LAST  = BEAT_W'(BEATS - 1);
    localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MW_ACC = 2'd1,
        MR_ACC = 2'd2,
        F_ACC  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [STARVE_W-1:0]   starve_q, starve_d;
    logic [LINE_W-1:0]     f_line_q, f_line_d;
    logic [DATA_W-1:0]     mr_data_q, mr_data_d;
    logic                  f_done_q, f_done_d;
    logic                  mr_done_q, mr_done_d;
    logic                  mw_done_q, mw_done_d;

    logic                  arb_en;
    logic                  fetch_force;
    logic                  grant_f, grant_mw, grant_mr;
    logic [ADDR_W-1:0]     fetch_addr;

    // The cycle carrying a done pulse is a dead IDLE cycle: the finishing requester
    // still holds its req there, so arbitrating would re-issue its access.
    assign arb_en      = (state_q == IDLE) && !(f_done_q || mr_done_q || mw_done_q);
    assign fetch_force = f_req_i && (starve_q == STARVE_TOP);
    assign grant_f     = arb_en && (fetch_force || (f_req_i && !mw_req_i && !mr_req_i));
    assign grant_mw    = arb_en && !fetch_force && mw_req_i;
    assign grant_mr    = arb_en && !fetch_force && !mw_req_i && mr_req_i;

    assign fetch_addr  = {f_addr_i[ADDR_W-1:OFF_W], beat_q, {WB_W{1'b0}}};

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        f_line_d  = f_line_q;
        mr_data_d = mr_data_q;
        f_done_d  = 1'b0;
        mr_done_d = 1'b0;
        mw_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!f_req_i) begin
                    beat_d = '0;
                end
                if (grant_f) begin
                    state_d = F_ACC;
                end else if (grant_mw) begin
                    state_d = MW_ACC;
                end else if (grant_mr) begin
                    state_d = MR_ACC;
                end
            end
            MW_ACC: begin
                if (mem_ack_i) begin
                    mw_done_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            MR_ACC: begin
                if (mem_ack_i) begin
                    mr_data_d = mem_rdata_i;
                    mr_done_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            F_ACC: begin
                if (mem_ack_i) begin
                    if (!f_req_i) begin
                        // Fetch was flushed: drop the beat, restart from beat 0 next time.
                        beat_d  = '0;
                        state_d = IDLE;
                    end else begin
                        for (int k = 0; k < BEATS; k++) begin
                            if (beat_q == BEAT_W'(k)) begin
                                f_line_d[k*DATA_W +: DATA_W] = mem_rdata_i;
                            end
                        end
                        if (beat_q == BEAT_LAST) begin
                            f_done_d = 1'b1;
                            beat_d   = '0;
                            state_d  = IDLE;
                        end else begin
                            beat_d = beat_q + 1'b1;
                            if (mw_req_i || mr_req_i) begin
                                state_d = IDLE;
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (!f_req_i || grant_f) begin
            starve_d = '0;
        end else if ((grant_mw || grant_mr) && (starve_q != STARVE_TOP)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            starve_q  <= '0;
            f_line_q  <= '0;
            mr_data_q <= '0;
            f_done_q  <= 1'b0;
            mr_done_q <= 1'b0;
            mw_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            starve_q  <= starve_d;
            f_line_q  <= f_line_d;
            mr_data_q <= mr_data_d;
            f_done_q  <= f_done_d;
            mr_done_q <= mr_done_d;
            mw_done_q <= mw_done_d;
        end
    end

    always_comb begin
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (state_q)
            MW_ACC: begin
                mem_addr_o  = mw_addr_i;
                mem_wdata_o = mw_wdata_i;
            end
            MR_ACC:  mem_addr_o = mr_addr_i;
            F_ACC:   mem_addr_o = fetch_addr;
            default: mem_addr_o = '0;
        endcase
    end

    assign mem_re_o   = (state_q == MR_ACC) || (state_q == F_ACC);
    assign mem_we_o   = (state_q == MW_ACC);
    assign f_done_o   = f_done_q;
    assign mr_done_o  = mr_done_q;
    assign mw_done_o  = mw_done_q;
    assign f_line_o   = f_line_q;
    assign mr_data_o  = mr_data_q;
    assign mr_stall_o = mr_req_i && !mr_done_q;
    assign mw_stall_o = mw_req_i && !mw_done_q;

endmodule
